serializer_ni_mvn: RTL and testbench
====================================

Name: serializer_ni_mvn

Overview:
Multi-virtual-network successor to the single-channel NI serializer. It accepts wide messages on NUM_VN independent input channels and buffers up to QUEUE_DEPTH messages per VN. Messages are arbitrated round-robin at message granularity, and each message is emitted as a stream of typed flits onto one shared router injection port under per-VN avail flow control. It sits between the tile-side message generators and the NoC router local input.

Parameters:
FLIT_SIZE, 64, flit payload width in bits.
FLIT_TYPE_SIZE, 2, flit type field width.
INPUT_WIDTH, 256, message width per VN; need not be a multiple of FLIT_SIZE.
NUM_VN, 3, number of virtual networks / input channels (1..8).
QUEUE_DEPTH, 2, messages buffered per VN (power of two, ≥1).
Derived: MAX_FLITS = ceil(INPUT_WIDTH/FLIT_SIZE); VN_W = max(1, Log2(NUM_VN)).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
req_in  in  NUM_VN  per-VN message push strobe.
data_in  in  NUM_VN*INPUT_WIDTH  per-VN message; VN v occupies slice [v*INPUT_WIDTH +: INPUT_WIDTH].
num_flits  in  NUM_VN*4  per-VN flit count of the pushed message.
bcast_in  in  NUM_VN  per-VN BroadcastL2 flag of the pushed message.
avail_in  in  NUM_VN  router has buffer space on VN v.
avail_out  out  NUM_VN  VN v can accept a push this cycle.
req_out  out  1  flit valid.
data_out  out  FLIT_SIZE  flit data; zero when req_out=0.
data_type_out  out  FLIT_TYPE_SIZE  `header / `payload / `tail / `header_tail.
vn_out  out  VN_W  VN of the current flit.
bcast_out  out  1  BroadcastL2 flag of the current message.
overflow_err  out  1  sticky: a push arrived while the VN was full.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - All FIFOs empty; round-robin pointer to VN0; no message locked.
  - req_out, data_out, data_type_out, vn_out, bcast_out and overflow_err all 0; avail_out all 1 after reset.
- Per-VN FIFO:
  - avail_out[v] = ~full[v] (combinational from the occupancy count).
  - Push on req_in[v] & ~full[v], storing {data, num_flits, bcast}.
  - req_in[v] while full: push dropped, FIFO unchanged, overflow_err set to 1 until reset.
  - Push and pop on the same VN in the same cycle are legal; occupancy is unchanged.
- num_flits normalisation at push: 0 is stored as 1; values > MAX_FLITS are stored as MAX_FLITS.
- States: IDLE, SEND.
  - IDLE: eligible VN = FIFO non-empty & avail_in[v]. Grant the first eligible VN starting from rr_ptr+1 (modulo NUM_VN). At the clock edge, register the header flit and go to SEND with lock_vn = granted VN (or directly stay in IDLE if that flit is header_tail). rr_ptr is updated to the granted VN.
  - SEND: each cycle, if avail_in[lock_vn]=1, register the next flit; otherwise register req_out=0 and hold the flit pointer (stall, no flit loss).
  - Tail registration pops the FIFO head and returns the block to IDLE. The next grant's header may be registered on the following edge, so back-to-back messages have no bubble.
- Outputs are registered. A message pushed at edge t into an empty system with avail_in=1 appears with req_out=1 in the cycle after edge t+1, i.e. one cycle of latency after the acceptance cycle.
- Flit i carries data[i*FLIT_SIZE +: FLIT_SIZE]. Bits beyond INPUT_WIDTH in the last possible flit are zero-padded.
- Flit type encoding:
  - Single-flit message: `header_tail.
  - Otherwise: first flit `header, last flit `tail, flits in between `payload.
- vn_out and bcast_out hold constant for all flits of a message.
- Flits of different messages are never interleaved. avail_in of non-locked VNs is ignored during SEND.

Test Plan:
1. Reset, then push on VN1 with num_flits=3, data words {W2,W1,W0}, avail_in=3'b111 → req_out high for 3 consecutive cycles; data W0,W1,W2; types `header,`payload,`tail; vn_out=1.
2. Push num_flits=0 on VN0 → exactly one flit of type `header_tail. Push num_flits=9 → 4 flits, with the upper 0 bits of the last flit zero-padded.
3. Simultaneous single-flit pushes on VN0, VN1 and VN2 from reset → emission order VN1, VN2, VN0 (rr starts at VN0 so VN1 is first), with no idle cycles between them.
4. During a 4-flit message on VN2, drop avail_in[2] for 2 cycles after the header → req_out=0 for 2 cycles, then `payload,`payload,`tail resume with no repeated or skipped flit.
5. Push 3 messages on VN0 with QUEUE_DEPTH=2 and avail_in=0 → avail_out[0] goes low after the 2nd push, the 3rd push is dropped, overflow_err=1. Raise avail_in → exactly 2 messages emitted.
6. Assert rst_n=0 mid-message → req_out, data_out and vn_out go to 0 asynchronously; after release, avail_out=all ones and no residual flits are emitted.

Source files
------------

// File: rtl/serializer_ni_mvn.sv
// Multi-VN NI serializer: per-VN message FIFOs, round-robin message arbitration, typed flit stream out.
// One cycle of latency after push acceptance; per-VN avail_in stalls the locked message without flit loss.
module serializer_ni_mvn #(
  parameter int FLIT_SIZE      = 64,
  parameter int FLIT_TYPE_SIZE = 2,
  parameter int INPUT_WIDTH    = 256,
  parameter int NUM_VN         = 3,
  parameter int QUEUE_DEPTH    = 2,
  localparam int VN_W          = (NUM_VN > 1) ? $clog2(NUM_VN) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_VN-1:0]             req_in,
  input  logic [NUM_VN*INPUT_WIDTH-1:0] data_in,
  input  logic [NUM_VN*4-1:0]           num_flits,
  input  logic [NUM_VN-1:0]             bcast_in,
  input  logic [NUM_VN-1:0]             avail_in,
  output logic [NUM_VN-1:0]             avail_out,
  output logic                          req_out,
  output logic [FLIT_SIZE-1:0]          data_out,
  output logic [FLIT_TYPE_SIZE-1:0]     data_type_out,
  output logic [VN_W-1:0]               vn_out,
  output logic                          bcast_out,
  output logic                          overflow_err
);

  localparam int MAX_FLITS = (INPUT_WIDTH + FLIT_SIZE - 1) / FLIT_SIZE;
  localparam int PAD_W     = MAX_FLITS * FLIT_SIZE;
  localparam int PW        = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW        = $clog2(QUEUE_DEPTH + 1);

  localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_HEADER      = FLIT_TYPE_SIZE'(0);
  localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_PAYLOAD     = FLIT_TYPE_SIZE'(1);
  localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_TAIL        = FLIT_TYPE_SIZE'(2);
  localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_HEADER_TAIL = FLIT_TYPE_SIZE'(3);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [INPUT_WIDTH-1:0] mem_dat [NUM_VN][QUEUE_DEPTH];
  logic [3:0]             mem_nf  [NUM_VN][QUEUE_DEPTH];
  logic                   mem_bc  [NUM_VN][QUEUE_DEPTH];
  logic [PW-1:0]          wr_ptr  [NUM_VN];
  logic [PW-1:0]          rd_ptr  [NUM_VN];
  logic [CW-1:0]          cnt     [NUM_VN];

  logic [NUM_VN-1:0] full, empty, push, pop, elig;

  logic [0:0]                state;
  logic [VN_W-1:0]           lock_vn;
  logic [VN_W-1:0]           rr_ptr;
  logic [3:0]                flit_idx;

  logic                      grant_vld;
  logic [VN_W-1:0]           grant_vn;
  logic [VN_W-1:0]           sel_vn;
  logic [3:0]                sel_idx;
  logic                      fire;
  logic                      last;
  logic [INPUT_WIDTH-1:0]    head_dat;
  logic [3:0]                head_nf;
  logic                      head_bc;
  logic [PAD_W-1:0]          padded;
  logic [FLIT_SIZE-1:0]      flit;
  logic [FLIT_TYPE_SIZE-1:0] ftype;

  // Stored flit counts are clamped so the FSM never indexes past the message.
  function automatic logic [3:0] norm_nf(input logic [3:0] n);
    if (n == 4'd0) return 4'd1;
    if (n > 4'(MAX_FLITS)) return 4'(MAX_FLITS);
    return n;
  endfunction

  always_comb begin
    full  = '0;
    empty = '0;
    push  = '0;
    for (int v = 0; v < NUM_VN; v++) begin
      full[v]  = (cnt[v] == CW'(QUEUE_DEPTH));
      empty[v] = (cnt[v] == '0);
      push[v]  = req_in[v] & ~full[v];
    end
  end

  assign avail_out = ~full;
  assign elig      = ~empty & avail_in;

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VN; v++) begin
      if (push[v]) begin
        mem_dat[v][wr_ptr[v]] <= data_in[v*INPUT_WIDTH +: INPUT_WIDTH];
        mem_nf[v][wr_ptr[v]]  <= norm_nf(num_flits[v*4 +: 4]);
        mem_bc[v][wr_ptr[v]]  <= bcast_in[v];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VN; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VN; v++) begin
        if (push[v]) wr_ptr[v] <= (wr_ptr[v] == PW'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr[v] + 1'b1;
        if (pop[v])  rd_ptr[v] <= (rd_ptr[v] == PW'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr[v] + 1'b1;
        case ({push[v], pop[v]})
          2'b10:   cnt[v] <= cnt[v] + 1'b1;
          2'b01:   cnt[v] <= cnt[v] - 1'b1;
          default: cnt[v] <= cnt[v];
        endcase
      end
    end
  end

  // Round-robin search starts one past the last granted VN.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_vn  = '0;
    for (int i = 1; i <= NUM_VN; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_VN;
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_vn  = VN_W'(idx);
      end
    end

    if (state == ST_IDLE) begin
      sel_vn  = grant_vn;
      sel_idx = 4'd0;
      fire    = grant_vld;
    end else begin
      sel_vn  = lock_vn;
      sel_idx = flit_idx;
      fire    = avail_in[lock_vn];
    end

    head_dat = mem_dat[sel_vn][rd_ptr[sel_vn]];
    head_nf  = mem_nf[sel_vn][rd_ptr[sel_vn]];
    head_bc  = mem_bc[sel_vn][rd_ptr[sel_vn]];

    padded = '0;
    padded[INPUT_WIDTH-1:0] = head_dat;
    flit = '0;
    for (int m = 0; m < MAX_FLITS; m++) begin
      if (sel_idx == 4'(m)) flit = padded[m*FLIT_SIZE +: FLIT_SIZE];
    end

    last = (sel_idx == head_nf - 4'd1);
    if (sel_idx == 4'd0) ftype = last ? TYPE_HEADER_TAIL : TYPE_HEADER;
    else                 ftype = last ? TYPE_TAIL : TYPE_PAYLOAD;

    pop = '0;
    if (fire && last) pop[sel_vn] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      lock_vn       <= '0;
      rr_ptr        <= '0;
      flit_idx      <= '0;
      req_out       <= 1'b0;
      data_out      <= '0;
      data_type_out <= '0;
      vn_out        <= '0;
      bcast_out     <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (|(req_in & full)) overflow_err <= 1'b1;
      if (fire) begin
        req_out       <= 1'b1;
        data_out      <= flit;
        data_type_out <= ftype;
        vn_out        <= sel_vn;
        bcast_out     <= head_bc;
        if (state == ST_IDLE) rr_ptr <= grant_vn;
        if (last) begin
          state <= ST_IDLE;
        end else begin
          state    <= ST_SEND;
          lock_vn  <= sel_vn;
          flit_idx <= sel_idx + 4'd1;
        end
      end else begin
        // Stall or idle: no flit this cycle, vn/bcast keep the current message's values.
        req_out       <= 1'b0;
        data_out      <= '0;
        data_type_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serializer_ni_mvn.sv
// Scoreboard bench for serializer_ni_mvn: expected flits queued at push time, popped by a negedge monitor.
module tb_serializer_ni_mvn;

  localparam int FS = 64;
  localparam int IW = 256;
  localparam int NV = 3;

  localparam logic [1:0] T_HDR = 2'd0;
  localparam logic [1:0] T_PAY = 2'd1;
  localparam logic [1:0] T_TL  = 2'd2;
  localparam logic [1:0] T_HT  = 2'd3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NV-1:0]   req_in = '0;
  logic [NV*IW-1:0] data_in = '0;
  logic [NV*4-1:0] num_flits = '0;
  logic [NV-1:0]   bcast_in = '0;
  logic [NV-1:0]   avail_in = '1;
  logic [NV-1:0]   avail_out;
  logic            req_out;
  logic [FS-1:0]   data_out;
  logic [1:0]      data_type_out;
  logic [1:0]      vn_out;
  logic            bcast_out;
  logic            overflow_err;

  serializer_ni_mvn dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .data_in(data_in),
    .num_flits(num_flits), .bcast_in(bcast_in), .avail_in(avail_in),
    .avail_out(avail_out), .req_out(req_out), .data_out(data_out),
    .data_type_out(data_type_out), .vn_out(vn_out), .bcast_out(bcast_out),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FS-1:0] dat;
    logic [1:0]    typ;
    logic [1:0]    vn;
    logic          bc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   flits_seen = 0;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (req_out) begin
        flits_seen++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_flit: got data=%h type=%0d vn=%0d, required no flit", data_out, data_type_out, vn_out);
        end else begin
          e = sb.pop_front();
          if ({data_out, data_type_out, vn_out, bcast_out} !== e) begin
            n_fail++;
            $display("FAIL flit: got data=%h type=%0d vn=%0d bc=%0d, required data=%h type=%0d vn=%0d bc=%0d",
                     data_out, data_type_out, vn_out, bcast_out, e.dat, e.typ, e.vn, e.bc);
          end
        end
      end else begin
        n_checks++;
        if (data_out !== '0) begin
          n_fail++;
          $display("FAIL idle_data: got %h, required 0", data_out);
        end
      end
    end
  end

  function automatic logic [IW-1:0] rand_msg();
    logic [IW-1:0] r;
    for (int i = 0; i < IW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Queue the flits a message should produce, in emission order.
  task automatic expect_msg(input int vn, input logic [IW-1:0] d, input logic [3:0] nf, input logic bc);
    int   n;
    exp_t e;
    n = (nf == 0) ? 1 : ((nf > 4) ? 4 : int'(nf));
    for (int i = 0; i < n; i++) begin
      e.dat = d[i*FS +: FS];
      e.typ = (n == 1) ? T_HT : (i == 0) ? T_HDR : (i == n-1) ? T_TL : T_PAY;
      e.vn  = 2'(vn);
      e.bc  = bc;
      sb.push_back(e);
    end
  endtask

  task automatic set_push(input int vn, input logic [IW-1:0] d, input logic [3:0] nf, input logic bc, input bit exp);
    req_in[vn]              = 1'b1;
    data_in[vn*IW +: IW]    = d;
    num_flits[vn*4 +: 4]    = nf;
    bcast_in[vn]            = bc;
    if (exp) expect_msg(vn, d, nf, bc);
  endtask

  task automatic clock_push();
    @(posedge clk);
    #1;
    req_in = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    req_in   = '0;
    avail_in = '1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({req_out, data_out, data_type_out, vn_out, bcast_out, overflow_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%0d data=%h type=%0d vn=%0d bc=%0d ovf=%0d, required all 0",
               req_out, data_out, data_type_out, vn_out, bcast_out, overflow_err);
    end
    n_checks++;
    if (avail_out !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_avail: got %b, required 111", avail_out);
    end
  endtask

  task automatic test_basic();
    set_push(1, rand_msg(), 4'd3, 1'b0, 1'b1);
    clock_push();
    @(negedge clk);
    n_checks++;
    if (req_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: got req_out=%0d one cycle early, required 0", req_out);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_out !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_burst: flit %0d got req_out=%0d, required 1", k, req_out);
      end
    end
    @(negedge clk);
    n_checks++;
    if (req_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_burst_end: got req_out=%0d, required 0", req_out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL basic_drain: got %0d flits pending, required 0", sb.size());
    end
  endtask

  task automatic test_flit_count();
    int base;
    base = flits_seen;
    set_push(0, rand_msg(), 4'd0, 1'b1, 1'b1);
    clock_push();
    drain();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (flits_seen - base != 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL nf_zero: got %0d flits (%0d pending), required 1", flits_seen - base, sb.size());
    end
    base = flits_seen;
    set_push(0, rand_msg(), 4'd9, 1'b0, 1'b1);
    clock_push();
    drain();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (flits_seen - base != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL nf_clamp: got %0d flits (%0d pending), required 4", flits_seen - base, sb.size());
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [3];
    order[0] = 2'd1;
    order[1] = 2'd2;
    order[2] = 2'd0;
    apply_reset();
    set_push(1, rand_msg(), 4'd1, 1'b1, 1'b1);
    set_push(2, rand_msg(), 4'd1, 1'b0, 1'b1);
    set_push(0, rand_msg(), 4'd1, 1'b1, 1'b1);
    clock_push();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_out !== 1'b1 || vn_out !== order[k]) begin
        n_fail++;
        $display("FAIL rr_order: slot %0d got req=%0d vn=%0d, required req=1 vn=%0d", k, req_out, vn_out, order[k]);
      end
    end
    @(posedge clk);
    #1;
    drain();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rr_drain: got %0d flits pending, required 0", sb.size());
    end
  endtask

  task automatic test_stall();
    int base;
    base = flits_seen;
    set_push(2, rand_msg(), 4'd4, 1'b1, 1'b1);
    clock_push();
    @(posedge clk);
    #1;
    n_checks++;
    if (req_out !== 1'b1 || data_type_out !== T_HDR) begin
      n_fail++;
      $display("FAIL stall_header: got req=%0d type=%0d, required req=1 type=%0d", req_out, data_type_out, T_HDR);
    end
    avail_in = 3'b011;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (req_out !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got req_out=%0d, required 0", k, req_out);
      end
    end
    avail_in = 3'b111;
    drain();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (flits_seen - base != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall_count: got %0d flits (%0d pending), required 4", flits_seen - base, sb.size());
    end
  endtask

  task automatic test_overflow();
    int base;
    base = flits_seen;
    avail_in = 3'b000;
    set_push(0, rand_msg(), 4'd2, 1'b1, 1'b1);
    clock_push();
    n_checks++;
    if (avail_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_avail1: got %0d, required 1", avail_out[0]);
    end
    set_push(0, rand_msg(), 4'd2, 1'b0, 1'b1);
    clock_push();
    n_checks++;
    if (avail_out[0] !== 1'b0 || overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full: got avail=%0d ovf=%0d, required avail=0 ovf=0", avail_out[0], overflow_err);
    end
    set_push(0, rand_msg(), 4'd2, 1'b1, 1'b0);
    clock_push();
    n_checks++;
    if (overflow_err !== 1'b1 || avail_out[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_flag: got ovf=%0d avail=%0d, required ovf=1 avail=0", overflow_err, avail_out[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (flits_seen != base) begin
      n_fail++;
      $display("FAIL ovf_blocked: got %0d flits while avail_in=0, required 0", flits_seen - base);
    end
    avail_in = 3'b111;
    drain();
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (flits_seen - base != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_emit: got %0d flits (%0d pending), required 4", flits_seen - base, sb.size());
    end
    n_checks++;
    if (overflow_err !== 1'b1 || avail_out !== 3'b111) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf=%0d avail=%b, required ovf=1 avail=111", overflow_err, avail_out);
    end
  endtask

  task automatic test_async_reset();
    int base;
    set_push(1, rand_msg(), 4'd4, 1'b1, 1'b1);
    clock_push();
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_checks++;
    if ({req_out, data_out, vn_out, data_type_out, overflow_err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%0d data=%h vn=%0d type=%0d ovf=%0d, required all 0",
               req_out, data_out, vn_out, data_type_out, overflow_err);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++;
    if (avail_out !== 3'b111) begin
      n_fail++;
      $display("FAIL async_reset_avail: got %b, required 111", avail_out);
    end
    mon_en = 1'b1;
    base = flits_seen;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (flits_seen != base) begin
      n_fail++;
      $display("FAIL async_reset_residual: got %0d flits, required 0", flits_seen - base);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_flit_count();
    test_round_robin();
    test_stall();
    test_overflow();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
